// File: rtl/lfsr_gen_if.sv
// lfsr_gen_if: control/status bundle of the LFSR generator.
// Ports: load/din/en/start/count in; q/sout/busy/done/lockup out.
interface lfsr_gen_if #(
  parameter int WIDTH = 26,
  parameter int CW    = 16
);
  logic             load;
  logic [1:WIDTH]   din;
  logic             en;
  logic             start;
  logic [CW-1:0]    count;
  logic [1:WIDTH]   q;
  logic             sout;
  logic             busy;
  logic             done;
  logic             lockup;

  modport master (
    output load, din, en, start, count,
    input  q, sout, busy, done, lockup
  );

  modport slave (
    input  load, din, en, start, count,
    output q, sout, busy, done, lockup
  );
endinterface

// File: rtl/lfsr_gen.sv
// lfsr_gen: Fibonacci/Galois LFSR with burst stepping and lock-up recovery.
// Ports: clk, rst_n (async low), bus (lfsr_gen_if.slave).
module lfsr_gen #(
  parameter int             WIDTH = 26,
  parameter logic [1:WIDTH] TAPS  = 26'b11000100000000000000000001,
  parameter bit             MODE  = 1'b0,
  parameter logic [1:WIDTH] SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int             CW    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  lfsr_gen_if.slave   bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state;
  logic [CW-1:0]  rem;
  logic [1:WIDTH] q;
  logic           done;
  logic [1:WIDTH] nxt;
  logic           zero;
  logic           fb;

  always_comb begin
    zero = ~|q;
    fb   = ^(q & TAPS);
    nxt  = q;
    if (zero)
      nxt = SEED;
    else if (MODE == 1'b0)
      nxt = {fb, q[1:WIDTH-1]};
    else
      nxt = {q[WIDTH],
             q[1:WIDTH-1] ^ ({(WIDTH-1){q[WIDTH]}} & TAPS[2:WIDTH])};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= SEED;
      state <= IDLE;
      rem   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.load) begin
        // load also aborts a burst without a done pulse
        q     <= bus.din;
        state <= IDLE;
        rem   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.start) begin
              if (bus.count != '0) begin
                rem   <= bus.count;
                state <= RUN;
              end else begin
                done <= 1'b1;
              end
            end else if (bus.en) begin
              q <= nxt;
            end
          end
          RUN: begin
            q   <= nxt;
            rem <= rem - 1'b1;
            if (rem == CW'(1)) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.q      = q;
  assign bus.sout   = q[WIDTH];
  assign bus.busy   = (state == RUN);
  assign bus.done   = done;
  assign bus.lockup = zero;

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised linear-feedback shift register that replaces the fixed 26-bit LFSR. It adds a configurable width, tap polynomial, Fibonacci or Galois structure, a counted-burst stepping mode with a busy/done handshake, and automatic recovery from the all-zero lock-up state. It sits beside the existing pattern and scrambler logic as the common pseudo-random source.

## Interface
- WIDTH, 26: register length, range 3..64.
- TAPS, 26'b11000100000000000000000001: tap mask indexed [1:WIDTH]; the default is x^26+x^6+x^2+x+1, with stages 1, 2, 6 and 26 set.
- MODE, 0: structure select; 0 = Fibonacci, 1 = Galois.
- SEED, 26'b1: reset and lock-up recovery value; must be nonzero.
- CW, 16: width of the burst count.
- clk  in  1  clock; rising edge active.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  parallel load of din.
- din  in  [1:WIDTH]  load value.
- en  in  1  free-run step enable; honoured only in IDLE.
- start  in  1  begins a burst of `count` steps; honoured only in IDLE.
- count  in  CW  number of burst steps; sampled when start is accepted.
- q  out  [1:WIDTH]  register state; bit 1 is the feedback-input end.
- sout  out  1  serial output, equal to q[WIDTH].
- busy  out  1  a burst is in progress.
- done  out  1  one-cycle pulse when a burst completes.
- lockup  out  1  combinational indicator; high when q is all zeros.

## Operation
- **Fibonacci step:** q[1] <= XOR of q[i] for every i where TAPS[i]=1; for i=2..WIDTH, q[i] <= q[i-1].
- **Galois step:** fb = q[WIDTH]; q[1] <= fb; for i=2..WIDTH, q[i] <= q[i-1] ^ (fb & TAPS[i]).
- **Lock-up recovery:** any step taken while q is all zeros loads SEED instead of shifting. A load of zero is legal and leaves lockup=1 until the next step.
- **FSM states:** IDLE and RUN, with an internal remaining-step counter `rem` of CW bits.
- **IDLE, start=1, count>0:** rem <= count; go to RUN. No step occurs on the accepting edge.
- **IDLE, start=1, count=0:** stay in IDLE; done pulses on the next cycle; q is unchanged.
- **IDLE, start=0, en=1:** one step per cycle.
- **RUN:** one step every cycle regardless of en; rem decrements each step. When the step taken with rem=1 completes, return to IDLE and pulse done.
- **start while in RUN:** ignored.
- **Priority:** load > start > en. load in IDLE overrides any start or en on the same edge.
- **load during RUN:** aborts the burst. q <= din, the FSM returns to IDLE, rem <= 0, and done does not pulse.

## Timing
- **Reset (asynchronous):** q=SEED, FSM=IDLE, rem=0, busy=0, done=0. sout and lockup follow q.
- busy = (state==RUN). It is registered and goes high the cycle after start is accepted.
- A burst of N steps holds busy high for exactly N cycles. done is high for the single cycle immediately after the final step, i.e. the first cycle with busy=0. q updates on each of the N edges.
- Load latency: q equals din in the cycle after the load edge.
- Free-run steps have one-cycle latency per step; q changes on the edge where en was sampled high.
- Reset asserted mid-burst aborts immediately: busy=0, done=0, q=SEED.
- sout and lockup have no registered delay relative to q.

## Test plan
- **Reset:** with defaults, assert rst_n=0 asynchronously at t=3 ns (mid-cycle) -> q=SEED (26'b1) immediately, busy=0, done=0, lockup=0.
- **Period check:** WIDTH=4, TAPS=4'b1001, MODE=0, SEED=4'b1000, en=1 -> q follows 1000, 1100, 1110, 1111, 0111, 1011, ... and returns to 1000 after exactly 15 steps with no earlier repeat. Repeat with MODE=1 and confirm period 15.
- **Load and lock-up:** defaults; load din=26'b11000010000100111100100111, then load din=0 -> lockup=1 and q holds 0 with en=0; one en cycle -> q=SEED and lockup=0.
- **Burst:** load 4'b1000 (WIDTH=4 config), then start with count=5 -> busy high for 5 cycles, q=1011 at the end, done high for 1 cycle. Start pulsed mid-burst is ignored.
- **Zero count:** start with count=0 -> done pulses the next cycle, busy stays 0, q is unchanged.
- **Abort:** start with count=10, then load din=4'b0101 at step 3 -> q=0101, busy=0 the next cycle, no done pulse. Separately, deassert rst_n mid-burst -> q=SEED, busy=0.
